// File: rtl/axi_slave_package.sv
// Shared slave-bridge definitions: Request Recorder geometry and the allocation arbiter state.
package axi_slave_package;

  localparam int unsigned REQUESTER_RECORDER_DEPTH = 32;
  localparam int unsigned REQUESTER_RECORDER_WIDTH = 64;
  localparam int unsigned REQUESTER_RECORDER_TAG_W = $clog2(REQUESTER_RECORDER_DEPTH);

  typedef enum logic {
    PRIO_RD = 1'b0,
    PRIO_WR = 1'b1
  } arb_prio_e;

endpackage

// File: rtl/request_recorder_slot_allocator_if.sv
// Allocation, recorder write-port and release signals between the push FSMs and the allocator.
interface request_recorder_slot_allocator_if #(
  parameter int unsigned REC_W = axi_slave_package::REQUESTER_RECORDER_WIDTH,
  parameter int unsigned TAG_W = axi_slave_package::REQUESTER_RECORDER_TAG_W
) ();

  logic             rd_alloc_req;
  logic [REC_W-1:0] rd_alloc_data;
  logic             rd_alloc_gnt;
  logic [TAG_W-1:0] rd_alloc_tag;
  logic             wr_alloc_req;
  logic [REC_W-1:0] wr_alloc_data;
  logic             wr_alloc_gnt;
  logic [TAG_W-1:0] wr_alloc_tag;
  logic             rec_wr_en;
  logic [TAG_W-1:0] rec_wr_addr;
  logic [REC_W-1:0] rec_wr_data;
  logic             free_valid;
  logic [TAG_W-1:0] free_tag;
  logic             free_err;
  logic [TAG_W:0]   outstanding_cnt;
  logic             full;
  logic             empty;

  modport master (
    output rd_alloc_req, rd_alloc_data, wr_alloc_req, wr_alloc_data, free_valid, free_tag,
    input  rd_alloc_gnt, rd_alloc_tag, wr_alloc_gnt, wr_alloc_tag, rec_wr_en, rec_wr_addr,
           rec_wr_data, free_err, outstanding_cnt, full, empty
  );

  modport slave (
    input  rd_alloc_req, rd_alloc_data, wr_alloc_req, wr_alloc_data, free_valid, free_tag,
    output rd_alloc_gnt, rd_alloc_tag, wr_alloc_gnt, wr_alloc_tag, rec_wr_en, rec_wr_addr,
           rec_wr_data, free_err, outstanding_cnt, full, empty
  );

endinterface

// File: rtl/recorder_free_slot_finder.sv
// Combinational find-first-zero over the recorder busy vector.
module recorder_free_slot_finder #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] busy,
  output logic             found,
  output logic [TAG_W-1:0] index
);

  // Scan downwards so the last hit, the lowest clear bit, wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        found = 1'b1;
        index = TAG_W'(i);
      end
    end
  end

endmodule

// File: rtl/request_recorder_slot_allocator.sv
// Hands out free Request Recorder tags to the read/write push paths (round-robin) and frees them.
module request_recorder_slot_allocator
  import axi_slave_package::*;
#(
  parameter int unsigned DEPTH = REQUESTER_RECORDER_DEPTH,
  parameter int unsigned REC_W = REQUESTER_RECORDER_WIDTH,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input logic                           clk,
  input logic                           ARESTn,
  request_recorder_slot_allocator_if.slave bus
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [TAG_W:0]   cnt_q, cnt_d;
  arb_prio_e        prio_q, prio_d;
  logic             rec_wr_en_q;
  logic [TAG_W-1:0] rec_wr_addr_q;
  logic [REC_W-1:0] rec_wr_data_q;
  logic             free_err_q;

  logic             slot_found;
  logic [TAG_W-1:0] slot_idx;
  logic             rd_win, wr_win, grant, free_ok;

  recorder_free_slot_finder #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_finder (
    .busy  (busy_q),
    .found (slot_found),
    .index (slot_idx)
  );

  // slot_found is false exactly when every entry is busy, i.e. when full.
  always_comb begin
    rd_win = ARESTn && slot_found && bus.rd_alloc_req && (!bus.wr_alloc_req || prio_q == PRIO_RD);
    wr_win = ARESTn && slot_found && bus.wr_alloc_req && (!bus.rd_alloc_req || prio_q == PRIO_WR);
    grant   = rd_win || wr_win;
    free_ok = bus.free_valid && busy_q[bus.free_tag];
  end

  always_comb begin
    busy_d = busy_q;
    if (free_ok) busy_d[bus.free_tag] = 1'b0;
    if (grant)   busy_d[slot_idx]     = 1'b1;

    cnt_d = cnt_q;
    if (grant && !free_ok)      cnt_d = cnt_q + (TAG_W + 1)'(1);
    else if (!grant && free_ok) cnt_d = cnt_q - (TAG_W + 1)'(1);

    prio_d = prio_q;
    if (rd_win)      prio_d = PRIO_WR;
    else if (wr_win) prio_d = PRIO_RD;
  end

  always_ff @(posedge clk) begin
    if (!ARESTn) begin
      busy_q        <= '0;
      cnt_q         <= '0;
      prio_q        <= PRIO_RD;
      rec_wr_en_q   <= 1'b0;
      rec_wr_addr_q <= '0;
      rec_wr_data_q <= '0;
      free_err_q    <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      rec_wr_en_q <= grant;
      free_err_q  <= bus.free_valid && !busy_q[bus.free_tag];
      if (grant) begin
        rec_wr_addr_q <= slot_idx;
        rec_wr_data_q <= rd_win ? bus.rd_alloc_data : bus.wr_alloc_data;
      end
    end
  end

  always_comb begin
    bus.rd_alloc_gnt    = rd_win;
    bus.rd_alloc_tag    = slot_idx;
    bus.wr_alloc_gnt    = wr_win;
    bus.wr_alloc_tag    = slot_idx;
    bus.rec_wr_en       = rec_wr_en_q;
    bus.rec_wr_addr     = rec_wr_addr_q;
    bus.rec_wr_data     = rec_wr_data_q;
    bus.free_err        = free_err_q;
    bus.outstanding_cnt = cnt_q;
    bus.full            = (cnt_q == (TAG_W + 1)'(DEPTH));
    bus.empty           = (cnt_q == '0);
  end

endmodule

// File: tb/tb_request_recorder_slot_allocator.sv
// Directed bench for the recorder slot allocator: arbitration, fill/free, same-cycle and reset cases.
module tb_request_recorder_slot_allocator;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned REC_W = 64;
  localparam int unsigned TAG_W = 5;

  logic clk = 1'b0;
  logic ARESTn;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  request_recorder_slot_allocator_if #(.REC_W(REC_W), .TAG_W(TAG_W)) bus ();

  request_recorder_slot_allocator #(
    .DEPTH (DEPTH),
    .REC_W (REC_W),
    .TAG_W (TAG_W)
  ) dut (
    .clk    (clk),
    .ARESTn (ARESTn),
    .bus    (bus)
  );

  task automatic idle_inputs();
    bus.rd_alloc_req  = 1'b0;
    bus.rd_alloc_data = '0;
    bus.wr_alloc_req  = 1'b0;
    bus.wr_alloc_data = '0;
    bus.free_valid    = 1'b0;
    bus.free_tag      = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    ARESTn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 ARESTn = 1'b1;
  endtask

  // Stimulus only: n lone read requests, one per cycle.
  task automatic alloc_rd(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rd_alloc_req  = 1'b1;
      bus.rd_alloc_data = 64'(i);
    end
    @(posedge clk);
    #1 bus.rd_alloc_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if (bus.outstanding_cnt !== 6'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      fails++;
      $display("FAIL reset_cnt: got cnt=%0d empty=%b full=%b, want 0/1/0",
               bus.outstanding_cnt, bus.empty, bus.full);
    end
    tests++;
    if (bus.rec_wr_en !== 1'b0 || bus.rec_wr_addr !== 5'd0 || bus.rec_wr_data !== 64'd0 ||
        bus.free_err !== 1'b0 || bus.rd_alloc_gnt !== 1'b0 || bus.wr_alloc_gnt !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%0h err=%b gnt=%b%b, want all 0",
               bus.rec_wr_en, bus.rec_wr_addr, bus.rec_wr_data, bus.free_err,
               bus.rd_alloc_gnt, bus.wr_alloc_gnt);
    end
  endtask

  task automatic test_single_rd();
    do_reset();
    @(negedge clk);
    bus.rd_alloc_req  = 1'b1;
    bus.rd_alloc_data = 64'hA5A5_0000_1234_5678;
    #1;
    tests++;
    if (bus.rd_alloc_gnt !== 1'b1 || bus.rd_alloc_tag !== 5'd0 || bus.wr_alloc_gnt !== 1'b0) begin
      fails++;
      $display("FAIL single_gnt: got rd_gnt=%b tag=%0d wr_gnt=%b, want 1 0 0",
               bus.rd_alloc_gnt, bus.rd_alloc_tag, bus.wr_alloc_gnt);
    end
    @(posedge clk);
    #1 bus.rd_alloc_req = 1'b0;
    tests++;
    if (bus.rec_wr_en !== 1'b1 || bus.rec_wr_addr !== 5'd0 ||
        bus.rec_wr_data !== 64'hA5A5_0000_1234_5678 || bus.outstanding_cnt !== 6'd1 ||
        bus.empty !== 1'b0) begin
      fails++;
      $display("FAIL single_write: got en=%b addr=%0d data=%0h cnt=%0d, want 1 0 a5a5000012345678 1",
               bus.rec_wr_en, bus.rec_wr_addr, bus.rec_wr_data, bus.outstanding_cnt);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.rec_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL single_en_pulse: got en=%b, want 0", bus.rec_wr_en);
    end
  endtask

  task automatic test_alternate();
    logic       exp_rd;
    logic [4:0] exp_tag;
    logic [63:0] exp_data;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.rd_alloc_req  = 1'b1;
      bus.wr_alloc_req  = 1'b1;
      bus.rd_alloc_data = 64'(100 + i);
      bus.wr_alloc_data = 64'(200 + i);
      exp_rd   = (i % 2 == 0);
      exp_tag  = 5'(i);
      exp_data = exp_rd ? 64'(100 + i) : 64'(200 + i);
      #1;
      tests++;
      if (bus.rd_alloc_gnt !== exp_rd || bus.wr_alloc_gnt !== !exp_rd ||
          (exp_rd ? bus.rd_alloc_tag : bus.wr_alloc_tag) !== exp_tag) begin
        fails++;
        $display("FAIL alt_gnt[%0d]: got rd=%b wr=%b rtag=%0d wtag=%0d, want rd=%b tag=%0d", i,
                 bus.rd_alloc_gnt, bus.wr_alloc_gnt, bus.rd_alloc_tag, bus.wr_alloc_tag,
                 exp_rd, exp_tag);
      end
      @(posedge clk);
      #1;
      tests++;
      if (bus.rec_wr_en !== 1'b1 || bus.rec_wr_addr !== exp_tag || bus.rec_wr_data !== exp_data) begin
        fails++;
        $display("FAIL alt_write[%0d]: got en=%b addr=%0d data=%0d, want 1 %0d %0d", i,
                 bus.rec_wr_en, bus.rec_wr_addr, bus.rec_wr_data, exp_tag, exp_data);
      end
    end
    bus.rd_alloc_req = 1'b0;
    bus.wr_alloc_req = 1'b0;
    tests++;
    if (bus.outstanding_cnt !== 6'd4) begin
      fails++;
      $display("FAIL alt_cnt: got %0d, want 4", bus.outstanding_cnt);
    end
  endtask

  task automatic test_full();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bus.rd_alloc_req = 1'b1;
      #1;
      if (bus.rd_alloc_gnt !== 1'b1 || bus.rd_alloc_tag !== 5'(i)) bad++;
    end
    @(posedge clk);
    #1 bus.rd_alloc_req = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL fill_tags: got %0d wrong grants, want 0", bad);
    end
    tests++;
    if (bus.full !== 1'b1 || bus.outstanding_cnt !== 6'd32) begin
      fails++;
      $display("FAIL fill_full: got full=%b cnt=%0d, want 1 32", bus.full, bus.outstanding_cnt);
    end
    @(negedge clk);
    bus.rd_alloc_req = 1'b1;
    bus.wr_alloc_req = 1'b1;
    #1;
    tests++;
    if (bus.rd_alloc_gnt !== 1'b0 || bus.wr_alloc_gnt !== 1'b0) begin
      fails++;
      $display("FAIL full_no_gnt: got rd=%b wr=%b, want 0 0", bus.rd_alloc_gnt, bus.wr_alloc_gnt);
    end
    @(negedge clk);
    bus.rd_alloc_req = 1'b0;
    bus.wr_alloc_req = 1'b0;
    bus.free_valid   = 1'b1;
    bus.free_tag     = 5'd5;
    @(posedge clk);
    #1 bus.free_valid = 1'b0;
    tests++;
    if (bus.full !== 1'b0 || bus.outstanding_cnt !== 6'd31 || bus.free_err !== 1'b0) begin
      fails++;
      $display("FAIL free5: got full=%b cnt=%0d err=%b, want 0 31 0",
               bus.full, bus.outstanding_cnt, bus.free_err);
    end
    @(negedge clk);
    bus.rd_alloc_req = 1'b1;
    #1;
    tests++;
    if (bus.rd_alloc_gnt !== 1'b1 || bus.rd_alloc_tag !== 5'd5) begin
      fails++;
      $display("FAIL refill_tag: got gnt=%b tag=%0d, want 1 5", bus.rd_alloc_gnt, bus.rd_alloc_tag);
    end
    @(posedge clk);
    #1 bus.rd_alloc_req = 1'b0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    alloc_rd(6);
    @(negedge clk);
    bus.rd_alloc_req = 1'b1;
    bus.free_valid   = 1'b1;
    bus.free_tag     = 5'd2;
    #1;
    tests++;
    if (bus.rd_alloc_gnt !== 1'b1 || bus.rd_alloc_tag !== 5'd6) begin
      fails++;
      $display("FAIL same_gnt: got gnt=%b tag=%0d, want 1 6", bus.rd_alloc_gnt, bus.rd_alloc_tag);
    end
    @(posedge clk);
    #1;
    bus.rd_alloc_req = 1'b0;
    bus.free_valid   = 1'b0;
    tests++;
    if (bus.outstanding_cnt !== 6'd6 || bus.rec_wr_addr !== 5'd6 || bus.free_err !== 1'b0) begin
      fails++;
      $display("FAIL same_cnt: got cnt=%0d addr=%0d err=%b, want 6 6 0",
               bus.outstanding_cnt, bus.rec_wr_addr, bus.free_err);
    end
    // Entry 2 must be the lowest free slot again.
    @(negedge clk);
    bus.rd_alloc_req = 1'b1;
    #1;
    tests++;
    if (bus.rd_alloc_gnt !== 1'b1 || bus.rd_alloc_tag !== 5'd2) begin
      fails++;
      $display("FAIL same_busy2: got gnt=%b tag=%0d, want 1 2", bus.rd_alloc_gnt, bus.rd_alloc_tag);
    end
    @(posedge clk);
    #1 bus.rd_alloc_req = 1'b0;
    // Entry 6 must still be busy: releasing it is clean and drops the count.
    @(negedge clk);
    bus.free_valid = 1'b1;
    bus.free_tag   = 5'd6;
    @(posedge clk);
    #1 bus.free_valid = 1'b0;
    tests++;
    if (bus.free_err !== 1'b0 || bus.outstanding_cnt !== 6'd6) begin
      fails++;
      $display("FAIL same_busy6: got err=%b cnt=%0d, want 0 6", bus.free_err, bus.outstanding_cnt);
    end
  endtask

  task automatic test_free_err();
    do_reset();
    alloc_rd(2);
    @(negedge clk);
    bus.free_valid = 1'b1;
    bus.free_tag   = 5'd9;
    @(posedge clk);
    #1 bus.free_valid = 1'b0;
    tests++;
    if (bus.free_err !== 1'b1 || bus.outstanding_cnt !== 6'd2) begin
      fails++;
      $display("FAIL err_pulse: got err=%b cnt=%0d, want 1 2", bus.free_err, bus.outstanding_cnt);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.free_err !== 1'b0 || bus.outstanding_cnt !== 6'd2) begin
      fails++;
      $display("FAIL err_one_cycle: got err=%b cnt=%0d, want 0 2", bus.free_err, bus.outstanding_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_rd(10);
    @(negedge clk);
    bus.rd_alloc_req = 1'b1;
    bus.wr_alloc_req = 1'b1;
    ARESTn           = 1'b0;
    @(posedge clk);
    #1 ARESTn = 1'b1;
    tests++;
    if (bus.outstanding_cnt !== 6'd0 || bus.empty !== 1'b1 || bus.rec_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got cnt=%0d empty=%b en=%b, want 0 1 0",
               bus.outstanding_cnt, bus.empty, bus.rec_wr_en);
    end
    @(negedge clk);
    #1;
    tests++;
    if (bus.rd_alloc_gnt !== 1'b1 || bus.wr_alloc_gnt !== 1'b0 || bus.rd_alloc_tag !== 5'd0) begin
      fails++;
      $display("FAIL mid_regrant: got rd=%b wr=%b tag=%0d, want 1 0 0",
               bus.rd_alloc_gnt, bus.wr_alloc_gnt, bus.rd_alloc_tag);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    ARESTn = 1'b0;
    idle_inputs();
    test_reset();
    test_single_rd();
    test_alternate();
    test_full();
    test_same_cycle();
    test_free_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/request_recorder_slot_allocator.md
# request_recorder_slot_allocator

- Allocates free entries (tags) of the AXI slave bridge Request Recorder to the read-request and write-request push paths, arbitrating between them round-robin.
- Writes the winning request's record into the recorder's request write port.
- Releases entries when the P2A response path reports completion.
- Sits between the slave-bridge push FSMs and the Request Recorder, and owns the recorder's busy/free bookkeeping.

## Interface
Parameters:
- DEPTH, 32: number of recorder entries; power of two, ≥2
- REC_W, 64: record width in bits
- TAG_W, $clog2(DEPTH): tag/address width

Ports:
- clk  in  1  clock
- ARESTn  in  1  reset; synchronous, active-low
- rd_alloc_req  in  1  read path requests an entry; held until granted
- rd_alloc_data  in  REC_W  record to store for the read request
- rd_alloc_gnt  out  1  read request granted this cycle
- rd_alloc_tag  out  TAG_W  allocated entry index; valid with rd_alloc_gnt
- wr_alloc_req  in  1  write path requests an entry
- wr_alloc_data  in  REC_W  record for the write request
- wr_alloc_gnt  out  1  write request granted this cycle
- wr_alloc_tag  out  TAG_W  allocated entry index
- rec_wr_en  out  1  Request Recorder request-port write enable
- rec_wr_addr  out  TAG_W  recorder write address
- rec_wr_data  out  REC_W  recorder write data
- free_valid  in  1  response path releases an entry
- free_tag  in  TAG_W  entry being released
- free_err  out  1  one-cycle pulse: release of an entry that was not busy
- outstanding_cnt  out  TAG_W+1  number of busy entries
- full  out  1  outstanding_cnt == DEPTH
- empty  out  1  outstanding_cnt == 0

## Operation
- State: busy[DEPTH-1:0], outstanding_cnt, arbiter pointer (states PRIO_RD / PRIO_WR), registered write-port outputs.
- Free slot = lowest-index clear bit of busy, computed from the current busy vector only. A slot freed in cycle N is allocatable from N+1.
- Arbitration, when at least one request is present and not full:
  - only one requester: it is granted;
  - both requesters: the one favoured by the pointer is granted.
- After a grant, the pointer moves to favour the other path: a read grant moves it to PRIO_WR, a write grant to PRIO_RD. With no grant, the pointer holds.
- At most one grant per cycle. The losing requester keeps its req asserted.
- When full: no grant and the pointer holds.
- On grant, at the clock edge:
  - busy[tag] is set;
  - the record is captured into rec_wr_data and tag into rec_wr_addr;
  - rec_wr_en is asserted for exactly one cycle.
- Release (free_valid):
  - if busy[free_tag]=1, it is cleared;
  - otherwise there is no state change and free_err pulses the next cycle.
- Counter update: +1 on grant, −1 on a valid release, unchanged when both occur in the same cycle.
- Grant and release in the same cycle always touch different entries, since a granted entry was free. Both take effect.
- Reset (ARESTn=0 at a clock edge):
  - busy, counter, rec_wr_en, rec_wr_addr, rec_wr_data, free_err and both gnts return to 0;
  - pointer returns to PRIO_RD; empty=1, full=0.
  - Applies mid-operation; records in flight are discarded.

## Timing
- rd/wr_alloc_gnt and *_alloc_tag are combinational from req, busy and pointer, in the same cycle as the request.
- Grant at cycle N:
  - rec_wr_en=1 with addr/data at N+1;
  - outstanding_cnt, full and empty reflect the grant at N+1.
- Release at N: the counter and the busy bit update at N+1; free_err (if applicable) is high at N+1 only.
- Sustained throughput: one allocation per cycle until full.

## Structure
- Shared package axi_slave_package holds:
  - REQUESTER_RECORDER_DEPTH and REQUESTER_RECORDER_WIDTH (defaults for DEPTH/REC_W);
  - a TAG_W localparam;
  - the arbiter enum (PRIO_RD, PRIO_WR).
- One sub-module: recorder_free_slot_finder, a combinational find-first-zero over busy that outputs found and index.
- Everything else stays flat in this module.

## Test plan
- Reset, then rd_alloc_req alone → rd_alloc_gnt=1 with tag 0 the same cycle; next cycle rec_wr_en=1, addr=0, data=rd_alloc_data; cnt=1.
- rd and wr requests held together for 4 cycles from reset → grants alternate rd,wr,rd,wr with tags 0,1,2,3; cnt=4.
- 32 allocations → full=1. Further requests get no grant. free_tag=5 → next cycle full=0 and the following grant returns tag 5.
- Same-cycle grant (tag 6) with release of tag 2 at cnt=6 → cnt stays 6; busy[6]=1, busy[2]=0.
- Release of a non-busy tag 9 → free_err high for exactly one cycle; cnt unchanged.
- ARESTn low for one cycle at cnt=10 with a grant pending → cnt=0, empty=1, rec_wr_en=0; the next grant returns tag 0 and the pointer favours rd.
